// File: rtl/occ_lookup_arbiter_pkg.sv
// Shared seeding-engine constants and the OCC read arbiter's AR-side state encoding.
// Pure declarations; no timing or flow control of its own.
package occ_lookup_arbiter_pkg;

    localparam int NUM_SEED_ENG   = 4;
    localparam int OCC_RD_AW      = 40;
    localparam int OCC_DW         = 256;
    localparam int OCC_RD_OUTS_AW = 3;

    typedef enum logic {
        S_Idle = 1'b0,
        S_Addr = 1'b1
    } ar_state_e;

endpackage

// File: rtl/occ_lookup_arbiter_fifo.sv
// Generic synchronous stream FIFO, 2^AW entries; pop data is visible in the cycle an entry is present.
// o_push_rdy low when full; pop only when o_pop_vld && i_pop_rdy.
module occ_lookup_arbiter_fifo #(
    parameter int DW = 2,
    parameter int AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push_vld,
    output logic          o_push_rdy,
    input  logic [DW-1:0] i_push_dat,
    output logic          o_pop_vld,
    input  logic          i_pop_rdy,
    output logic [DW-1:0] o_pop_dat,
    output logic [AW:0]   o_count
);

    logic [DW-1:0] r_mem [2**AW];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_push;
    logic          w_pop;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign o_push_rdy = !((r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]));
    assign o_pop_vld  = (r_wptr != r_rptr);
    assign o_pop_dat  = r_mem[r_rptr[AW-1:0]];
    assign o_count    = r_wptr - r_rptr;
    assign w_push     = i_push_vld && o_push_rdy;
    assign w_pop      = o_pop_vld && i_pop_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/occ_lookup_arbiter.sv
// Round-robin share of one AXI4-Lite OCC read port among NREQ engines; AR adds 1 cycle, R is 0-cycle pass-through.
// AR grants stall while 2^OUTS_AW reads are in flight; R backpressure from the head requester stalls the master.
module occ_lookup_arbiter
    import occ_lookup_arbiter_pkg::*;
#(
    parameter int NREQ    = NUM_SEED_ENG,
    parameter int OCC_AW  = OCC_RD_AW,
    parameter int DW      = OCC_DW,
    parameter int OUTS_AW = OCC_RD_OUTS_AW
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NREQ-1:0][OCC_AW-1:0]  s_araddr,
    input  logic [NREQ-1:0]              s_arvalid,
    output logic [NREQ-1:0]              s_arready,
    output logic [DW-1:0]                s_rdata,
    output logic [1:0]                   s_rresp,
    output logic [NREQ-1:0]              s_rvalid,
    input  logic [NREQ-1:0]              s_rready,
    output logic [OCC_AW-1:0]            m_araddr,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    input  logic [DW-1:0]                m_rdata,
    input  logic [1:0]                   m_rresp,
    input  logic                         m_rvalid,
    output logic                         m_rready,
    output logic [OUTS_AW:0]             outstanding
);

    localparam int IW = $clog2(NREQ);

    ar_state_e          r_state;
    ar_state_e          w_state_nxt;
    logic [IW-1:0]      r_rr;
    logic [IW-1:0]      r_grant;
    logic [OCC_AW-1:0]  r_araddr;
    logic [IW:0]        w_pick;
    logic               w_win;
    logic               w_push;
    logic               w_pop;
    logic               w_not_full;
    logic               w_fifo_vld;
    logic [IW-1:0]      w_head;

    // Returns {found, index} of the first requester at or above ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] pick;
        int          idx;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) pick = {1'b1, idx[IW-1:0]};
        end
        return pick;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_Idle;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win       = 1'b0;
        w_pick      = rr_pick(s_arvalid, r_rr);
        case (r_state)
            S_Idle: begin
                if (w_pick[IW] && w_not_full) begin
                    w_state_nxt = S_Addr;
                    w_win       = 1'b1;
                end
            end
            S_Addr: begin
                if (m_arready) w_state_nxt = S_Idle;
            end
            default: w_state_nxt = S_Idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr     <= '0;
            r_grant  <= '0;
            r_araddr <= '0;
        end else begin
            if (w_win) begin
                r_grant  <= w_pick[IW-1:0];
                r_araddr <= s_araddr[w_pick[IW-1:0]];
            end
            if (w_push) r_rr <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + IW'(1);
        end
    end

    assign m_arvalid = (r_state == S_Addr);
    assign m_araddr  = r_araddr;
    assign w_push    = m_arvalid && m_arready;

    always_comb begin
        s_arready = '0;
        if (m_arvalid) s_arready[r_grant] = m_arready;
    end

    // The order FIFO records which requester owns each in-flight read.
    occ_lookup_arbiter_fifo #(
        .DW (IW),
        .AW (OUTS_AW)
    ) u_order_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_push_vld (w_push),
        .o_push_rdy (w_not_full),
        .i_push_dat (r_grant),
        .o_pop_vld  (w_fifo_vld),
        .i_pop_rdy  (w_pop),
        .o_pop_dat  (w_head),
        .o_count    (outstanding)
    );

    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign m_rready = w_fifo_vld && s_rready[w_head];
    assign w_pop    = m_rvalid && m_rready;

    always_comb begin
        s_rvalid = '0;
        if (w_fifo_vld) s_rvalid[w_head] = m_rvalid;
    end

    a_r_beat_has_owner: assert property (@(posedge clk) disable iff (!reset_n) m_rvalid |-> w_fifo_vld);

endmodule

// File: tb/tb_occ_lookup_arbiter.sv
// Bench for occ_lookup_arbiter: expected AR grants and R routing are queued when stimulus is driven
// and checked by a negedge monitor when the DUT handshakes.
module tb_occ_lookup_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 40;
    localparam int DW   = 256;
    localparam int OAW  = 3;

    logic                      clk;
    logic                      reset_n;
    logic [NREQ-1:0][AW-1:0]   s_araddr;
    logic [NREQ-1:0]           s_arvalid;
    logic [NREQ-1:0]           s_arready;
    logic [DW-1:0]             s_rdata;
    logic [1:0]                s_rresp;
    logic [NREQ-1:0]           s_rvalid;
    logic [NREQ-1:0]           s_rready;
    logic [AW-1:0]             m_araddr;
    logic                      m_arvalid;
    logic                      m_arready;
    logic [DW-1:0]             m_rdata;
    logic [1:0]                m_rresp;
    logic                      m_rvalid;
    logic                      m_rready;
    logic [OAW:0]              outstanding;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
    } ar_exp_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int      pend_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    occ_lookup_arbiter #(
        .NREQ    (NREQ),
        .OCC_AW  (AW),
        .DW      (DW),
        .OUTS_AW (OAW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_araddr    (s_araddr),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .m_araddr    (m_araddr),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .outstanding (outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are stable between the negedge and the following posedge, so they are judged here.
    ar_exp_t         mon_ae;
    r_exp_t          mon_re;
    logic [NREQ-1:0] mon_oh;
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_arvalid && m_arready) begin
                check_eq("ar_expected", 256'(ar_q.size() != 0), 256'(1));
                if (ar_q.size() != 0) begin
                    mon_ae = ar_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_ae.idx] = 1'b1;
                    check_eq("ar_addr", m_araddr, mon_ae.addr);
                    check_eq("ar_grant", s_arready, mon_oh);
                end
            end
            if (m_rvalid && m_rready) begin
                check_eq("r_expected", 256'(r_q.size() != 0), 256'(1));
                if (r_q.size() != 0) begin
                    mon_re = r_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_re.idx] = 1'b1;
                    check_eq("r_owner", s_rvalid, mon_oh);
                    check_eq("r_data", s_rdata, mon_re.data);
                    check_eq("r_resp", s_rresp, mon_re.resp);
                end
            end
        end
    end

    // Advance one cycle; requesters drop arvalid after their handshake edge.
    task automatic tick();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = s_arvalid & s_arready;
        @(posedge clk);
        #2;
        s_arvalid = s_arvalid & ~hs;
        #1;
    endtask

    task automatic req_ar(input int idx, input logic [AW-1:0] addr);
        s_araddr[idx]  = addr;
        s_arvalid[idx] = 1'b1;
        ar_q.push_back('{idx, addr});
        pend_q.push_back(idx);
    endtask

    task automatic wait_ar();
        for (int i = 0; i < 80; i++) begin
            if (ar_q.size() == 0 && s_arvalid == '0) break;
            tick();
        end
        check_eq("ar_drained", 256'(ar_q.size()), 256'(0));
    endtask

    task automatic r_beat(input int idx);
        r_exp_t e;
        logic   done;
        e.idx  = idx;
        e.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
        e.resp = 2'($urandom_range(0, 3));
        r_q.push_back(e);
        m_rdata  = e.data;
        m_rresp  = e.resp;
        m_rvalid = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (m_rready) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check_eq("r_accepted", 256'(done), 256'(1));
        tick();
        m_rvalid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) r_beat(pend_q.pop_front());
    endtask

    initial begin
        reset_n   = 1'b0;
        s_araddr  = '0;
        s_arvalid = '0;
        s_rready  = '1;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_eq("rst_arvalid", m_arvalid, 0);
        check_eq("rst_araddr", m_araddr, 0);
        check_eq("rst_arready", s_arready, 0);
        check_eq("rst_rvalid", s_rvalid, 0);
        check_eq("rst_mrready", m_rready, 0);
        check_eq("rst_outstanding", outstanding, 0);
        reset_n = 1'b1;
        tick();

        // Single requester, one cycle of arbitration latency.
        m_arready = 1'b1;
        req_ar(2, 40'h40);
        #1;
        check_eq("single_lat0", m_arvalid, 0);
        tick();
        check_eq("single_arvalid", m_arvalid, 1);
        check_eq("single_araddr", m_araddr, 40'h40);
        check_eq("single_arready", s_arready, 4'b0100);
        tick();
        check_eq("single_outs1", outstanding, 1);
        check_eq("single_arvalid_off", m_arvalid, 0);
        drain(1);
        check_eq("single_outs0", outstanding, 0);

        // Bring the pointer back to 0, then contend with all four.
        req_ar(3, 40'h300);
        wait_ar();
        drain(1);
        for (int i = 0; i < NREQ; i++) req_ar(i, 40'h1000 + 40'(i * 16));
        wait_ar();
        req_ar(0, 40'h2000);
        req_ar(3, 40'h2030);
        wait_ar();
        check_eq("contend_outs", outstanding, 6);
        drain(6);

        // Ordering across two requesters.
        req_ar(1, 40'h111);
        wait_ar();
        req_ar(3, 40'h333);
        wait_ar();
        check_eq("order_outs", outstanding, 2);
        drain(2);

        // Full: eight accepted, ninth waits until one R pop.
        for (int k = 0; k < 8; k++) begin
            req_ar(k % NREQ, 40'h8000 + 40'(k));
            wait_ar();
        end
        req_ar(0, 40'h9999);
        repeat (4) tick();
        check_eq("full_outs", outstanding, 8);
        check_eq("full_no_arvalid", m_arvalid, 0);
        check_eq("full_no_arready", s_arready, 0);
        r_beat(pend_q.pop_front());
        check_eq("full_pop_outs", outstanding, 7);
        check_eq("full_pop_arvalid", m_arvalid, 0);
        tick();
        check_eq("full_regrant", m_arvalid, 1);
        wait_ar();
        check_eq("full_refill", outstanding, 8);
        drain(8);

        // R backpressure on the head while another AR waits; both complete on one edge.
        req_ar(1, 40'hB1);
        wait_ar();
        m_arready   = 1'b0;
        s_rready[1] = 1'b0;
        begin
            r_exp_t e;
            e.idx  = 1;
            e.data = {8{32'hC0FFEE11}};
            e.resp = 2'b10;
            r_q.push_back(e);
            m_rdata  = e.data;
            m_rresp  = e.resp;
            m_rvalid = 1'b1;
        end
        req_ar(2, 40'hB2);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_mrready", m_rready, 0);
            check_eq("bp_rvalid", s_rvalid, 4'b0010);
            check_eq("bp_rdata", s_rdata, {8{32'hC0FFEE11}});
            tick();
        end
        check_eq("bp_outs", outstanding, 1);
        m_arready   = 1'b1;
        s_rready[1] = 1'b1;
        #1;
        check_eq("bp_release_rready", m_rready, 1);
        check_eq("bp_release_arready", s_arready, 4'b0100);
        tick();
        m_rvalid = 1'b0;
        check_eq("bp_same_cycle_outs", outstanding, 1);
        void'(pend_q.pop_front());
        drain(1);

        // Asynchronous reset with reads in flight.
        for (int i = 0; i < 3; i++) req_ar(i, 40'hE00 + 40'(i));
        wait_ar();
        check_eq("rst_mid_outs3", outstanding, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_outs0", outstanding, 0);
        check_eq("rst_mid_arvalid", m_arvalid, 0);
        check_eq("rst_mid_araddr", m_araddr, 0);
        check_eq("rst_mid_mrready", m_rready, 0);
        pend_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        req_ar(3, 40'hF3);
        wait_ar();
        check_eq("post_rst_outs", outstanding, 1);
        drain(1);
        check_eq("post_rst_outs0", outstanding, 0);

        check_eq("ar_q_empty", 256'(ar_q.size()), 256'(0));
        check_eq("r_q_empty", 256'(r_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
